// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and constants for the MINI_CPU sequencer:
//                FSM state encoding, instruction classes, ALU opcodes and
//                instruction field bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Register file geometry
    localparam int NUM_REGS = 4;
    localparam int DATA_W   = 8;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Instruction classes (bits [15:14])
    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_LDI  = 2'b01,
        CLS_BRZ  = 2'b10,
        CLS_HALT = 2'b11
    } iclass_t;

    // ALU operation codes driven on alu_op
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Instruction field bit positions
    localparam int CLS_MSB = 15;
    localparam int CLS_LSB = 14;
    localparam int OP_MSB  = 13;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Extract the instruction class from a full instruction word
    function automatic iclass_t f_class(input logic [15:0] instr);
        return iclass_t'(instr[CLS_MSB:CLS_LSB]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_regfile
//  Description : 4 x 8-bit register file with two combinational read ports,
//                one combinational debug read port and one synchronous
//                write port. Synchronous active-high reset clears all entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_regfile
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [1:0]        i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [1:0]        i_ra1,
    input  logic [1:0]        i_ra2,
    input  logic [1:0]        i_dbg_sel,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    output logic [DATA_W-1:0] o_dbg
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Synchronous write port; reads see the pre-write value in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = r_regs[i_ra1];
    assign o_rd2 = r_regs[i_ra2];
    assign o_dbg = r_regs[i_dbg_sel];

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl
//  Description : Multi-cycle FETCH/DECODE/EXEC sequencer for the MINI_CPU.
//                Fetches 16-bit instructions from a synchronous ROM, drives
//                the external 8-bit ALU, writes results to a 4 x 8 register
//                file and tracks the zero flag for BRZ.
//                Optional feature macro: CPU_CTRL_PERF_CNT_EN adds a
//                saturating retired-instruction counter output.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] instr_addr,
    input  logic [15:0]     instr_data,
    output logic [7:0]      op_a,
    output logic [7:0]      op_b,
    output logic [1:0]      alu_op,
    input  logic [7:0]      result,
    input  logic            zero,
    input  logic [1:0]      dbg_sel,
    output logic [7:0]      dbg_data
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]     retired_cnt
`endif
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic            r_zflag;
    logic            r_busy;
    logic            r_done;

    iclass_t         w_class;
    logic [1:0]      w_op;
    logic [1:0]      w_rd;
    logic [1:0]      w_rs1;
    logic [1:0]      w_rs2;
    logic [7:0]      w_imm;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_exec;
    logic            w_alu_en;
    logic            w_rf_we;
    logic [7:0]      w_rf_wd;
    logic [7:0]      w_rd1;
    logic [7:0]      w_rd2;

    // Instruction field decode from the latched instruction register
    assign w_class  = f_class(r_ir);
    assign w_op     = r_ir[OP_MSB:OP_LSB];
    assign w_rd     = r_ir[RD_MSB:RD_LSB];
    assign w_rs1    = r_ir[RS1_MSB:RS1_LSB];
    assign w_rs2    = r_ir[RS2_MSB:RS2_LSB];
    assign w_imm    = r_ir[IMM_MSB:IMM_LSB];
    assign w_target = r_ir[PC_W-1:0];
    assign w_pc_inc = r_pc + PC_W'(1);

    assign w_exec   = (r_state == ST_EXEC);
    assign w_alu_en = w_exec && (w_class == CLS_ALU);
    assign w_rf_we  = w_exec && ((w_class == CLS_ALU) || (w_class == CLS_LDI));
    assign w_rf_wd  = (w_class == CLS_ALU) ? result : w_imm;

    cpu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_rf_we),
        .i_wa      (w_rd),
        .i_wd      (w_rf_wd),
        .i_ra1     (w_rs1),
        .i_ra2     (w_rs2),
        .i_dbg_sel (dbg_sel),
        .o_rd1     (w_rd1),
        .o_rd2     (w_rd2),
        .o_dbg     (dbg_data)
    );

    // ALU operands are forced to zero outside EXEC of an ALU instruction
    assign op_a       = w_alu_en ? w_rd1 : 8'h00;
    assign op_b       = w_alu_en ? w_rd2 : 8'h00;
    assign alu_op     = w_alu_en ? w_op  : ALU_ADD;
    assign instr_addr = (r_state == ST_FETCH) ? r_pc : '0;
    assign busy       = r_busy;
    assign done       = r_done;

    // Sequencer FSM with registered busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_zflag <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_pc    <= '0;
                        r_zflag <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir    <= instr_data;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    unique case (w_class)
                        CLS_ALU: begin
                            r_zflag <= zero;
                            r_pc    <= w_pc_inc;
                            r_state <= ST_FETCH;
                        end
                        CLS_LDI: begin
                            r_pc    <= w_pc_inc;
                            r_state <= ST_FETCH;
                        end
                        CLS_BRZ: begin
                            r_pc    <= r_zflag ? w_target : w_pc_inc;
                            r_state <= ST_FETCH;
                        end
                        CLS_HALT: begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    endcase
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CPU_CTRL_PERF_CNT_EN
    logic [15:0] r_retired_cnt;

    // Saturating count of executed instructions, cleared on each accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_retired_cnt <= '0;
        end else if (w_exec && (r_retired_cnt != 16'hFFFF)) begin
            r_retired_cnt <= r_retired_cnt + 16'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

endmodule
`default_nettype wire
